// File: rtl/cen_pkg.sv
// Shared types and constants for the clock-enable scheduler.
package cen_pkg;

   typedef enum logic [1:0] {RUN, DRAIN, PAUSED} state_e;

   localparam logic SEL_CPU = 1'b0;
   localparam logic SEL_SND = 1'b1;

   localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/cen_channel.sv
// One divider channel: counter, pending/active ratio, cen pulse and phase output.
module cen_channel
   import cen_pkg::*;
#(
   parameter int unsigned CNT_W   = 6,
   parameter int unsigned RST_DIV = 8
) (
   input  logic             clkin,
   input  logic             reset,
   input  logic             hold,
   input  logic             stall,
   input  logic             wr,
   input  logic [CNT_W-1:0] wr_div,
   output logic             top_c,
   output logic             cen,
   output logic             phi
);

   logic [CNT_W-1:0] cnt, div_act, div_pend;
   logic [CNT_W-1:0] cnt_nxt, div_nxt, wr_clamped;
   logic             adv_c, wrap_c;

   // Stall only bites at the top count; hold freezes everything.
   always_comb begin
      top_c      = (cnt == div_act - CNT_W'(1));
      adv_c      = !hold && !(top_c && stall);
      wrap_c     = adv_c && top_c;
      cnt_nxt    = cnt;
      div_nxt    = div_act;
      wr_clamped = (wr_div < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : wr_div;
      if (wrap_c) begin
         cnt_nxt = '0;
         div_nxt = div_pend;
      end else if (adv_c) begin
         cnt_nxt = cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         cnt      <= '0;
         div_act  <= CNT_W'(RST_DIV);
         div_pend <= CNT_W'(RST_DIV);
         cen      <= 1'b0;
         phi      <= 1'b0;
      end else begin
         cnt     <= cnt_nxt;
         div_act <= div_nxt;
         cen     <= wrap_c;
         phi     <= (cnt_nxt >= (div_nxt >> 1));
         // A write coinciding with a wrap lands in pending for the next wrap.
         if (wr) begin
            div_pend <= wr_clamped;
         end
      end
   end

endmodule

// File: rtl/cen_scheduler.sv
// Central CPU/sound clock-enable scheduler with wait stretching and pause handshake.
module cen_scheduler
   import cen_pkg::*;
#(
   parameter int unsigned CNT_W   = 6,
   parameter int unsigned CPU_DIV = 8,
   parameter int unsigned SND_DIV = 16
) (
   input  logic             clkin,
   input  logic             reset,
   input  logic             cpu_wait,
   input  logic             pause_req,
   output logic             pause_ack,
   input  logic             cfg_we,
   input  logic             cfg_sel,
   input  logic [CNT_W-1:0] cfg_div,
   output logic             cpu_cen,
   output logic             cpu_phi,
   output logic             snd_cen
);

   state_e state;
   logic   cpu_top_c, snd_top_unused;
   logic   take_pause_c, freeze_c, cpu_wr_c, snd_wr_c;

   // The pausing CPU wrap is swallowed and both channels freeze on that same edge.
   always_comb begin
      take_pause_c = (state == DRAIN) && pause_req && cpu_top_c && !cpu_wait;
      freeze_c     = (state == PAUSED) || take_pause_c;
      cpu_wr_c     = cfg_we && (cfg_sel == SEL_CPU);
      snd_wr_c     = cfg_we && (cfg_sel == SEL_SND);
   end

   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         state     <= RUN;
         pause_ack <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (pause_req) state <= DRAIN;
            end
            DRAIN: begin
               if (!pause_req) begin
                  state <= RUN;
               end else if (take_pause_c) begin
                  state     <= PAUSED;
                  pause_ack <= 1'b1;
               end
            end
            PAUSED: begin
               if (!pause_req) begin
                  state     <= RUN;
                  pause_ack <= 1'b0;
               end
            end
            default: begin
               state     <= RUN;
               pause_ack <= 1'b0;
            end
         endcase
      end
   end

   cen_channel #(.CNT_W(CNT_W), .RST_DIV(CPU_DIV)) u_cpu (
      .clkin  (clkin),
      .reset  (reset),
      .hold   (freeze_c),
      .stall  (cpu_wait),
      .wr     (cpu_wr_c),
      .wr_div (cfg_div),
      .top_c  (cpu_top_c),
      .cen    (cpu_cen),
      .phi    (cpu_phi)
   );

   cen_channel #(.CNT_W(CNT_W), .RST_DIV(SND_DIV)) u_snd (
      .clkin  (clkin),
      .reset  (reset),
      .hold   (freeze_c),
      .stall  (1'b0),
      .wr     (snd_wr_c),
      .wr_div (cfg_div),
      .top_c  (snd_top_unused),
      .cen    (snd_cen),
      .phi    ()
   );

endmodule

// File: tb/tb_cen_scheduler.sv
// Directed and randomized bench for cen_scheduler against a cycle-level reference model.
module tb_cen_scheduler;

   logic       clkin = 1'b0;
   logic       reset = 1'b1;
   logic       cpu_wait = 1'b0;
   logic       pause_req = 1'b0;
   logic       cfg_we = 1'b0;
   logic       cfg_sel = 1'b0;
   logic [5:0] cfg_div = 6'd0;
   logic       pause_ack, cpu_cen, cpu_phi, snd_cen;

   int checks = 0;
   int errors = 0;

   // reference model: index 0 = CPU, 1 = sound; mode 0 run, 1 drain, 2 paused
   int m_cnt[2], m_div[2], m_pend[2];
   int m_mode;
   int e_cen[2];
   int e_phi, e_ack;

   int cyc, first_cpu, first_snd, last_cpu, last_snd, cpu_period, snd_period;
   int ack_seen, cen_seen;

   cen_scheduler #(.CNT_W(6), .CPU_DIV(8), .SND_DIV(16)) dut (
      .clkin     (clkin),
      .reset     (reset),
      .cpu_wait  (cpu_wait),
      .pause_req (pause_req),
      .pause_ack (pause_ack),
      .cfg_we    (cfg_we),
      .cfg_sel   (cfg_sel),
      .cfg_div   (cfg_div),
      .cpu_cen   (cpu_cen),
      .cpu_phi   (cpu_phi),
      .snd_cen   (snd_cen)
   );

   always #5 clkin = ~clkin;

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_cnt[0] = 0;  m_cnt[1] = 0;
      m_div[0] = 8;  m_div[1] = 16;
      m_pend[0] = 8; m_pend[1] = 16;
      m_mode = 0;
      e_cen[0] = 0; e_cen[1] = 0; e_phi = 0; e_ack = 0;
      cyc = 0; first_cpu = -1; first_snd = -1; last_cpu = -1; last_snd = -1;
      cpu_period = 0; snd_period = 0;
   endtask

   // Advance the model by one clkin edge using the currently driven inputs.
   task automatic m_step();
      bit cpu_top, freeze, go;
      cpu_top = (m_cnt[0] == m_div[0] - 1);
      freeze  = (m_mode == 2) || (m_mode == 1 && pause_req && cpu_top && !cpu_wait);
      for (int c = 0; c < 2; c++) begin
         go = !freeze && !(c == 0 && cpu_top && cpu_wait);
         e_cen[c] = 0;
         if (go) begin
            if (m_cnt[c] == m_div[c] - 1) begin
               m_cnt[c] = 0;
               m_div[c] = m_pend[c];
               e_cen[c] = 1;
            end else begin
               m_cnt[c] = m_cnt[c] + 1;
            end
         end
         if (cfg_we && int'(cfg_sel) == c)
            m_pend[c] = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
      end
      e_phi = (m_cnt[0] >= m_div[0] / 2) ? 1 : 0;
      case (m_mode)
         0: if (pause_req) m_mode = 1;
         1: if (!pause_req) m_mode = 0;
            else if (cpu_top && !cpu_wait) m_mode = 2;
         default: if (!pause_req) m_mode = 0;
      endcase
      e_ack = (m_mode == 2) ? 1 : 0;
   endtask

   task automatic step();
      m_step();
      @(posedge clkin);
      #1;
      cyc++;
      chk_int("cpu_cen", int'(cpu_cen), e_cen[0]);
      chk_int("snd_cen", int'(snd_cen), e_cen[1]);
      chk_int("cpu_phi", int'(cpu_phi), e_phi);
      chk_int("pause_ack", int'(pause_ack), e_ack);
      if (cpu_cen === 1'b1) begin
         if (last_cpu < 0) first_cpu = cyc; else cpu_period = cyc - last_cpu;
         last_cpu = cyc;
         cen_seen++;
      end
      if (snd_cen === 1'b1) begin
         if (last_snd < 0) first_snd = cyc; else snd_period = cyc - last_snd;
         last_snd = cyc;
         cen_seen++;
      end
      if (pause_ack === 1'b1) ack_seen++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_cpu_cnt(input int v);
      int found = 0;
      for (int i = 0; i < 200 && found == 0; i++) begin
         if (m_cnt[0] == v) found = 1; else step();
      end
      chk_int("wait_cnt_timeout", found, 1);
   endtask

   task automatic run_to_cpu_cen();
      int found = 0;
      for (int i = 0; i < 200 && found == 0; i++) begin
         step();
         if (e_cen[0] == 1) found = 1;
      end
      chk_int("cpu_cen_timeout", found, 1);
   endtask

   task automatic run_to_snd_cen();
      int found = 0;
      for (int i = 0; i < 200 && found == 0; i++) begin
         step();
         if (e_cen[1] == 1) found = 1;
      end
      chk_int("snd_cen_timeout", found, 1);
   endtask

   task automatic run_to_paused();
      int found = 0;
      for (int i = 0; i < 300 && found == 0; i++) begin
         step();
         if (m_mode == 2) found = 1;
      end
      chk_int("pause_timeout", found, 1);
   endtask

   task automatic cfg_write(input logic sel, input int d);
      cfg_we = 1'b1; cfg_sel = sel; cfg_div = 6'(d);
      step();
      cfg_we = 1'b0;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk_int({tag, "_cpu_cen"}, int'(cpu_cen), 0);
      chk_int({tag, "_snd_cen"}, int'(snd_cen), 0);
      chk_int({tag, "_cpu_phi"}, int'(cpu_phi), 0);
      chk_int({tag, "_pause_ack"}, int'(pause_ack), 0);
   endtask

   initial begin
      m_reset();
      #12;
      chk_outputs_zero("reset");
      @(posedge clkin); #1;
      reset = 1'b0;
      m_reset();

      // default ratios
      run(40);
      chk_int("first_cpu_cen", first_cpu, 8);
      chk_int("first_snd_cen", first_snd, 16);
      chk_int("cpu_period", cpu_period, 8);
      chk_int("snd_period", snd_period, 16);

      // wait stretch across the top count
      wait_cpu_cnt(7);
      cpu_wait = 1'b1;
      run(5);
      cpu_wait = 1'b0;
      run_to_cpu_cen();
      chk_int("wait_cpu_period", cpu_period, 13);
      run_to_snd_cen();
      chk_int("wait_snd_period", snd_period, 16);

      // pause and resume
      wait_cpu_cnt(2);
      pause_req = 1'b1;
      run_to_paused();
      chk_int("paused_cnt", m_cnt[0], 7);
      cen_seen = 0;
      run(10);
      chk_int("cen_in_pause", cen_seen, 0);
      pause_req = 1'b0;
      step();
      chk_int("ack_fall", int'(pause_ack), 0);
      step();
      chk_int("resume_cpu_cen", int'(cpu_cen), 1);
      run(20);

      // aborted drain
      wait_cpu_cnt(1);
      ack_seen = 0;
      pause_req = 1'b1;
      run(2);
      pause_req = 1'b0;
      run(20);
      chk_int("abort_ack_seen", ack_seen, 0);
      chk_int("abort_cpu_period", cpu_period, 8);

      // reprogramming the CPU ratio
      wait_cpu_cnt(3);
      cfg_write(1'b0, 5);
      run_to_cpu_cen();
      chk_int("reprog_old_period", cpu_period, 8);
      run_to_cpu_cen();
      chk_int("reprog_5", cpu_period, 5);
      cfg_write(1'b0, 1);
      run_to_cpu_cen();
      run_to_cpu_cen();
      chk_int("reprog_clamp_2", cpu_period, 2);
      cfg_write(1'b0, 0);
      cfg_write(1'b0, 12);
      run_to_cpu_cen();
      run_to_cpu_cen();
      chk_int("reprog_12", cpu_period, 12);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         cpu_wait = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 19) == 0) pause_req = ~pause_req;
         cfg_we  = ($urandom_range(0, 15) == 0);
         cfg_sel = 1'($urandom_range(0, 1));
         cfg_div = ($urandom_range(0, 9) == 0) ? 6'd63 : 6'($urandom_range(0, 15));
         step();
      end
      cfg_we = 1'b0;
      cpu_wait = 1'b0;

      // asynchronous reset while paused
      pause_req = 1'b1;
      run_to_paused();
      chk_int("paused_ack", int'(pause_ack), 1);
      #2;
      reset = 1'b1;
      #1;
      chk_outputs_zero("async_reset");
      pause_req = 1'b0;
      @(posedge clkin); #1;
      reset = 1'b0;
      m_reset();
      run(40);
      chk_int("post_reset_first_cpu", first_cpu, 8);
      chk_int("post_reset_cpu_period", cpu_period, 8);
      chk_int("post_reset_snd_period", snd_period, 16);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cen_scheduler.md
Name: cen_scheduler

Overview:
- Central clock-enable scheduler for the core. It derives the CPU and sound clock enables from the master clock clkin.
- The CPU enable can be stretched by memory wait requests.
- Both enables can be frozen through a pause request/acknowledge handshake for the OSD and save states.
- Divide ratios can be reprogrammed at run time and take effect glitch-free at each channel's wrap.

Parameters:
- CNT_W, 6, width of the divider counters and cfg_div; the maximum ratio is 2^CNT_W-1.
- CPU_DIV, 8, reset divide ratio of the CPU channel; legal range 2..2^CNT_W-1.
- SND_DIV, 16, reset divide ratio of the sound channel; legal range 2..2^CNT_W-1.

Ports:
- clkin  in  1  master clock; the only clock in the block.
- reset  in  1  asynchronous, active-high reset.
- cpu_wait  in  1  memory busy; stretches the CPU cycle.
- pause_req  in  1  level request to freeze both channels.
- pause_ack  out  1  high while both channels are frozen.
- cfg_we  in  1  single-cycle write strobe for a new ratio.
- cfg_sel  in  1  target channel: 0 = CPU, 1 = sound.
- cfg_div  in  CNT_W  new divide ratio.
- cpu_cen  out  1  one-clkin-wide CPU clock enable.
- cpu_phi  out  1  CPU phase square wave.
- snd_cen  out  1  one-clkin-wide sound clock enable.

Behaviour:
- Clock and reset: one clock, clkin. reset is asynchronous and active-high.
- Reset values:
  - Both counters 0.
  - Active and pending ratios equal CPU_DIV and SND_DIV.
  - FSM in RUN.
  - cpu_cen, snd_cen, cpu_phi and pause_ack all 0.
- Reset mid-pause or mid-drain returns the FSM to RUN immediately.
- Channel counter: cnt counts 0..div-1. A wrap is the cycle with cnt == div-1 and the counter allowed to advance. On a wrap the counter loads 0 and the pending ratio is copied to the active ratio.
- Outputs are registered and update on the same edge as the counter. Each channel's first cen therefore appears div cycles after reset release.
- cen: a channel's cen is high for exactly one clkin cycle per wrap.
- cpu_phi = (cnt >= div/2) using integer division.
  - For div = 8 this gives 4 cycles low and 4 cycles high, identical to the legacy divide-by-8 square clock.
  - For odd div the high half is the longer one.
- Wait:
  - cpu_wait is sampled only when the CPU cnt == div-1.
  - If cpu_wait is high then, the counter holds at div-1, cpu_cen stays 0 and cpu_phi stays 1.
  - The wrap and cpu_cen occur in the first cycle cpu_wait is sampled low.
  - cpu_wait at any other count has no effect.
  - The sound channel ignores cpu_wait.
- Pause FSM, states RUN, DRAIN and PAUSED:
  - RUN → DRAIN when pause_req = 1.
  - DRAIN → RUN when pause_req = 0. No cycle is lost.
  - DRAIN → PAUSED when the CPU cnt == div-1 with cpu_wait = 0 and pause_req = 1.
    - That wrap is suppressed: no cpu_cen, counter held at div-1.
    - The sound counter freezes at its current value in the same cycle.
  - PAUSED:
    - pause_ack = 1.
    - Both counters frozen.
    - Both cen outputs 0.
    - cpu_phi holds its value.
  - PAUSED → RUN when pause_req = 0.
    - pause_ack falls in that cycle.
    - The CPU wrap fires in the next cycle if cpu_wait = 0; otherwise normal wait rules apply.
  - The sound channel continues normally in DRAIN.
- Configuration:
  - cfg_we writes cfg_div into the pending ratio of the channel selected by cfg_sel. The active ratio is unchanged until that channel's next wrap.
  - cfg_div < 2 is clamped to 2.
  - A second write before the wrap overwrites the pending value.
  - A write in the same cycle as a wrap lands in pending and applies at the following wrap.
  - Writes are accepted in every FSM state.
- Arithmetic: unsigned CNT_W bits throughout. No counter wrap-around beyond div-1 is possible.

Decomposition:
- Shared package cen_pkg:
  - FSM state enum (RUN, DRAIN, PAUSED).
  - Channel select constants SEL_CPU = 0 and SEL_SND = 1.
  - Constant MIN_DIV = 2.
- Sub-module cen_channel, instantiated twice. It contains:
  - counter
  - pending and active ratio registers
  - clamp logic
  - cen and phi generation
  - inputs hold (freeze) and stall (wait)
- cen_scheduler itself contains the pause FSM, stall gating and cfg decode.

Test Plan:
- Default ratios after reset release: cpu_cen pulses every 8 cycles and snd_cen every 16; cpu_phi is low for 4 cycles then high for 4; first cpu_cen 8 cycles after release.
- Wait stretch: hold cpu_wait = 1 for 5 cycles spanning cnt = 7 → CPU period is 13 cycles, cpu_phi is high for 9, and the snd_cen period stays 16.
- Pause: assert pause_req at CPU cnt = 2 → pause_ack rises at the cnt = 7 cycle with no cpu_cen, and no cen appears while paused. Release pause_req → cpu_cen occurs one cycle after pause_ack falls, and the sound count resumes from its frozen value.
- Abort drain: pulse pause_req for 2 cycles at CPU cnt = 1 → pause_ack never rises and the cpu_cen period stays exactly 8.
- Reprogram: write CPU ratio 5 at cnt = 3 → the current period completes at 8 and subsequent periods are 5. Write 1 → periods become 2. Write 0 then 12 before the wrap → periods become 12.
- Reset mid-pause: assert reset while PAUSED → all outputs go to 0 asynchronously, ratios return to 8 and 16, and normal operation resumes after release.
